trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter IRQ_SYNC_STAGES, default 2, giving the synchronizer depth for raw interrupt lines (legal 2..4).
REQ-002 The block SHALL have port clk  input  1  the single clock; all flops rise-edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports ext_irq_raw, tmr_irq_raw, sw_irq_raw  input  1 each  asynchronous interrupt sources.
REQ-005 The block SHALL have ports external_interrupt, timer_interrupt, software_interrupt  output  1 each  synchronized lines to the CSR file.
REQ-006 The block SHALL have ports retire_valid  input  1  and retire_pc, retire_next_pc  input  32  instruction at retirement boundary.
REQ-007 The block SHALL have ports retire_exc  input  1, retire_cause  input  31, retire_tval  input  32  synchronous exception of retiring instruction.
REQ-008 The block SHALL have ports retire_mret, retire_wfi  input  1  retiring instruction is MRET / WFI.
REQ-009 The block SHALL have ports interrupted  input  1, trap_pc, ret_pc  input  32  from the CSR file.
REQ-010 The block SHALL have ports handle_trap, exit_trap, exception  output  1; exception_cause  output  31; trap_value, current_pc  output  32  to the CSR file.
REQ-011 The block SHALL have ports redirect_valid  output  1, redirect_ready  input  1, redirect_pc  output  32  fetch redirect handshake; stall  output  1  freezes retirement.

Function
REQ-012 Each raw irq SHALL pass through an IRQ_SYNC_STAGES-deep flop chain; output = last stage.
REQ-013 States SHALL be RUN, TRAP, RET, and WAIT (WAIT only with macro).
REQ-014 In RUN with retire_valid, priority SHALL be retire_exc > interrupted > retire_mret > retire_wfi.
REQ-015 Exception: same cycle handle_trap=1, exception=1, exception_cause=retire_cause, trap_value=retire_tval, current_pc=retire_pc; next state TRAP.
REQ-016 Interrupt: same cycle handle_trap=1, exception=0, trap_value=0, current_pc=retire_next_pc; next state TRAP.
REQ-017 MRET: same cycle exit_trap=1; next state RET.
REQ-018 handle_trap and exit_trap SHALL each be single-cycle pulses and never both high.
REQ-019 TRAP: redirect_valid=1, redirect_pc=trap_pc registered on entry; RET: likewise with ret_pc.
REQ-020 redirect_pc SHALL be stable while redirect_valid && !redirect_ready; on handshake, next state RUN and redirect_valid drops next cycle.
REQ-021 stall SHALL be 1 in TRAP, RET, WAIT; 0 in RUN; retire_* inputs SHALL be ignored while stall=1.
REQ-022 interrupted asserting during TRAP/RET SHALL be ignored until RUN (taken on next retire_valid).
REQ-023 retire_valid=0 in RUN SHALL produce no pulses and no state change.

Reset
REQ-024 Reset SHALL asynchronously force state RUN, all sync flops 0, registered redirect_pc 0; all outputs 0 while reset is high.
REQ-025 Reset mid-TRAP/RET SHALL abandon the redirect with no handshake required; first cycle after release is RUN.

Configuration
REQ-026 Macro TRAP_CTRL_WFI_EN SHALL enable WFI handling; undefined: retire_wfi ignored, WAIT state absent.
REQ-027 With the macro, RUN + retire_valid + retire_wfi (no higher priority) SHALL latch retire_next_pc and enter WAIT.
REQ-028 WAIT SHALL exit when any synchronized irq is 1: if interrupted, pulse handle_trap (exception=0, current_pc=latched PC) and go TRAP; else go RUN with no redirect.

Verification
REQ-029 Exception: retire_valid, retire_exc, cause=2, pc=0x100, tval=0xdead, trap_pc=0x80 -> handle_trap pulse, exception=1, current_pc=0x100; next cycle redirect_valid, redirect_pc=0x80.
REQ-030 Interrupt: ext_irq_raw held, interrupted=1, retire_next_pc=0x204 -> external_interrupt after 2 cycles; handle_trap, exception=0, current_pc=0x204.
REQ-031 Backpressure: redirect_ready low 5 cycles -> redirect_valid/redirect_pc=0x80 held and stall=1 throughout; RUN one cycle after ready.
REQ-032 MRET with ret_pc=0x300, retire_exc=1 same cycle -> exception wins, no exit_trap; MRET alone -> exit_trap pulse, redirect_pc=0x300.
REQ-033 WFI (macro on): retire_wfi at 0x40 -> stall=1; tmr_irq_raw with interrupted=0 -> RUN, no redirect; macro off -> no stall.
REQ-034 Reset asserted while in TRAP with redirect pending -> redirect_valid=0 immediately; RUN after release.

Source files
------------

// File: rtl/trap_ctrl.sv
// Trap sequencer between retirement, the CSR file and fetch redirect.
// Define TRAP_CTRL_WFI_EN to add WFI handling (WAIT state).
module trap_ctrl #(
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ext_irq_raw,
  input  logic        tmr_irq_raw,
  input  logic        sw_irq_raw,
  output logic        external_interrupt,
  output logic        timer_interrupt,
  output logic        software_interrupt,
  input  logic        retire_valid,
  input  logic [31:0] retire_pc,
  input  logic [31:0] retire_next_pc,
  input  logic        retire_exc,
  input  logic [30:0] retire_cause,
  input  logic [31:0] retire_tval,
  input  logic        retire_mret,
  input  logic        retire_wfi,
  input  logic        interrupted,
  input  logic [31:0] trap_pc,
  input  logic [31:0] ret_pc,
  output logic        handle_trap,
  output logic        exit_trap,
  output logic        exception,
  output logic [30:0] exception_cause,
  output logic [31:0] trap_value,
  output logic [31:0] current_pc,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        stall
);

  typedef enum logic [1:0] {
    RUN,
    TRAP,
    RET
`ifdef TRAP_CTRL_WFI_EN
    , WAIT
`endif
  } state_t;

  state_t state;
  logic [IRQ_SYNC_STAGES-1:0] ext_sync, tmr_sync, sw_sync;
  logic take_exc, take_irq, take_mret;
`ifdef TRAP_CTRL_WFI_EN
  logic take_wfi, wake_trap, wake_run, irq_any;
  logic [31:0] wfi_pc;
`else
  logic unused_wfi;
  assign unused_wfi = retire_wfi;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_sync <= '0;
      tmr_sync <= '0;
      sw_sync  <= '0;
    end else begin
      ext_sync <= {ext_sync[IRQ_SYNC_STAGES-2:0], ext_irq_raw};
      tmr_sync <= {tmr_sync[IRQ_SYNC_STAGES-2:0], tmr_irq_raw};
      sw_sync  <= {sw_sync[IRQ_SYNC_STAGES-2:0], sw_irq_raw};
    end
  end

  assign external_interrupt = ext_sync[IRQ_SYNC_STAGES-1];
  assign timer_interrupt    = tmr_sync[IRQ_SYNC_STAGES-1];
  assign software_interrupt = sw_sync[IRQ_SYNC_STAGES-1];

  // Retirement decisions only happen in RUN; pulses are suppressed during reset.
  always_comb begin
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
`ifdef TRAP_CTRL_WFI_EN
    take_wfi  = 1'b0;
    wake_trap = 1'b0;
    wake_run  = 1'b0;
    irq_any   = external_interrupt | timer_interrupt | software_interrupt;
`endif
    if (!reset) begin
      if (state == RUN && retire_valid) begin
        if (retire_exc)        take_exc  = 1'b1;
        else if (interrupted)  take_irq  = 1'b1;
        else if (retire_mret)  take_mret = 1'b1;
`ifdef TRAP_CTRL_WFI_EN
        else if (retire_wfi)   take_wfi  = 1'b1;
`endif
      end
`ifdef TRAP_CTRL_WFI_EN
      if (state == WAIT && irq_any) begin
        if (interrupted) wake_trap = 1'b1;
        else             wake_run  = 1'b1;
      end
`endif
    end
  end

`ifdef TRAP_CTRL_WFI_EN
  assign handle_trap = take_exc | take_irq | wake_trap;
`else
  assign handle_trap = take_exc | take_irq;
`endif
  assign exit_trap       = take_mret;
  assign exception       = take_exc;
  assign exception_cause = take_exc ? retire_cause : '0;
  assign trap_value      = take_exc ? retire_tval : '0;

  always_comb begin
    current_pc = '0;
    if (take_exc)      current_pc = retire_pc;
    else if (take_irq) current_pc = retire_next_pc;
`ifdef TRAP_CTRL_WFI_EN
    else if (wake_trap) current_pc = wfi_pc;
`endif
  end

  // redirect_pc is captured on entry so it stays stable under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      redirect_pc <= '0;
`ifdef TRAP_CTRL_WFI_EN
      wfi_pc      <= '0;
`endif
    end else begin
      if (handle_trap) begin
        state       <= TRAP;
        redirect_pc <= trap_pc;
      end else if (exit_trap) begin
        state       <= RET;
        redirect_pc <= ret_pc;
      end
`ifdef TRAP_CTRL_WFI_EN
      else if (take_wfi) begin
        state  <= WAIT;
        wfi_pc <= retire_next_pc;
      end else if (wake_run) begin
        state <= RUN;
      end
`endif
      else if ((state == TRAP || state == RET) && redirect_ready) begin
        state <= RUN;
      end
    end
  end

  assign redirect_valid = (state == TRAP) || (state == RET);
  assign stall          = (state != RUN);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus a randomized run
// against a behavioural model of the trap/return rules.
module tb_trap_ctrl;
  localparam int N = 2;
`ifdef TRAP_CTRL_WFI_EN
  localparam bit WFI_EN = 1'b1;
`else
  localparam bit WFI_EN = 1'b0;
`endif

  logic clk, reset;
  logic ext_irq_raw, tmr_irq_raw, sw_irq_raw;
  logic external_interrupt, timer_interrupt, software_interrupt;
  logic retire_valid, retire_exc, retire_mret, retire_wfi, interrupted;
  logic [31:0] retire_pc, retire_next_pc, retire_tval, trap_pc, ret_pc;
  logic [30:0] retire_cause;
  logic handle_trap, exit_trap, exception, redirect_valid, redirect_ready, stall;
  logic [30:0] exception_cause;
  logic [31:0] trap_value, current_pc, redirect_pc;
  int checks = 0;
  int errors = 0;

  trap_ctrl #(.IRQ_SYNC_STAGES(N)) dut (
    .clk(clk), .reset(reset),
    .ext_irq_raw(ext_irq_raw), .tmr_irq_raw(tmr_irq_raw), .sw_irq_raw(sw_irq_raw),
    .external_interrupt(external_interrupt), .timer_interrupt(timer_interrupt),
    .software_interrupt(software_interrupt),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_next_pc(retire_next_pc),
    .retire_exc(retire_exc), .retire_cause(retire_cause), .retire_tval(retire_tval),
    .retire_mret(retire_mret), .retire_wfi(retire_wfi),
    .interrupted(interrupted), .trap_pc(trap_pc), .ret_pc(ret_pc),
    .handle_trap(handle_trap), .exit_trap(exit_trap), .exception(exception),
    .exception_cause(exception_cause), .trap_value(trap_value), .current_pc(current_pc),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ext_irq_raw = 0; tmr_irq_raw = 0; sw_irq_raw = 0;
    retire_valid = 0; retire_exc = 0; retire_mret = 0; retire_wfi = 0; interrupted = 0;
    retire_pc = '0; retire_next_pc = '0; retire_tval = '0; retire_cause = '0;
    trap_pc = '0; ret_pc = '0; redirect_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    retire_valid = 1; retire_exc = 1; retire_pc = 32'h10; ext_irq_raw = 1; interrupted = 1;
    @(negedge clk); #1;
    checks++; if (handle_trap !== 1'b0) begin errors++; $display("[TB] FAIL rst_handle_trap got %b want 0", handle_trap); end
    checks++; if (exception !== 1'b0) begin errors++; $display("[TB] FAIL rst_exception got %b want 0", exception); end
    checks++; if (current_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_current_pc got %h want 0", current_pc); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_redirect_valid got %b want 0", redirect_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall got %b want 0", stall); end
    checks++; if (external_interrupt !== 1'b0) begin errors++; $display("[TB] FAIL rst_ext_irq got %b want 0", external_interrupt); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL rst_redirect_pc got %h want 0", redirect_pc); end
    @(negedge clk);
    clear_inputs(); reset = 0;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_exception();
    clear_inputs();
    retire_valid = 1; retire_exc = 1; retire_cause = 31'd2; retire_pc = 32'h100;
    retire_tval = 32'hdead; trap_pc = 32'h80;
    #1;
    checks++; if (handle_trap !== 1'b1) begin errors++; $display("[TB] FAIL exc_handle_trap got %b want 1", handle_trap); end
    checks++; if (exception !== 1'b1) begin errors++; $display("[TB] FAIL exc_exception got %b want 1", exception); end
    checks++; if (exception_cause !== 31'd2) begin errors++; $display("[TB] FAIL exc_cause got %h want 2", exception_cause); end
    checks++; if (trap_value !== 32'hdead) begin errors++; $display("[TB] FAIL exc_tval got %h want dead", trap_value); end
    checks++; if (current_pc !== 32'h100) begin errors++; $display("[TB] FAIL exc_current_pc got %h want 100", current_pc); end
    checks++; if (exit_trap !== 1'b0) begin errors++; $display("[TB] FAIL exc_exit_trap got %b want 0", exit_trap); end
    @(negedge clk); #1;
    checks++; if (handle_trap !== 1'b0) begin errors++; $display("[TB] FAIL exc_pulse got %b want 0", handle_trap); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL exc_redirect_valid got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("[TB] FAIL exc_redirect_pc got %h want 80", redirect_pc); end
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL exc_stall got %b want 1", stall); end
    clear_inputs(); redirect_ready = 1;
    @(negedge clk); #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL exc_done_valid got %b want 0", redirect_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL exc_done_stall got %b want 0", stall); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    clear_inputs();
    retire_valid = 1; retire_exc = 1; retire_pc = 32'h120; trap_pc = 32'h80;
    @(negedge clk);
    clear_inputs();
    interrupted = 1; retire_valid = 1; retire_next_pc = 32'h500;
    for (int i = 0; i < 5; i++) begin
      trap_pc = $urandom;
      #1;
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b want 1", i, redirect_valid); end
      checks++; if (redirect_pc !== 32'h80) begin errors++; $display("[TB] FAIL bp_pc[%0d] got %h want 80", i, redirect_pc); end
      checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL bp_stall[%0d] got %b want 1", i, stall); end
      checks++; if (handle_trap !== 1'b0) begin errors++; $display("[TB] FAIL bp_irq_ignored[%0d] got %b want 0", i, handle_trap); end
      @(negedge clk);
    end
    redirect_ready = 1;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL bp_run_stall got %b want 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_run_valid got %b want 0", redirect_valid); end
    checks++; if (handle_trap !== 1'b1) begin errors++; $display("[TB] FAIL bp_late_irq got %b want 1", handle_trap); end
    checks++; if (current_pc !== 32'h500) begin errors++; $display("[TB] FAIL bp_late_irq_pc got %h want 500", current_pc); end
    clear_inputs(); redirect_ready = 1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_interrupt();
    clear_inputs();
    ext_irq_raw = 1;
    for (int i = 0; i < N; i++) begin
      #1;
      checks++; if (external_interrupt !== 1'b0) begin errors++; $display("[TB] FAIL irq_sync_early[%0d] got %b want 0", i, external_interrupt); end
      @(negedge clk);
    end
    #1;
    checks++; if (external_interrupt !== 1'b1) begin errors++; $display("[TB] FAIL irq_sync got %b want 1", external_interrupt); end
    interrupted = 1; retire_valid = 1; retire_pc = 32'h200; retire_next_pc = 32'h204; trap_pc = 32'h80;
    #1;
    checks++; if (handle_trap !== 1'b1) begin errors++; $display("[TB] FAIL irq_handle_trap got %b want 1", handle_trap); end
    checks++; if (exception !== 1'b0) begin errors++; $display("[TB] FAIL irq_exception got %b want 0", exception); end
    checks++; if (current_pc !== 32'h204) begin errors++; $display("[TB] FAIL irq_current_pc got %h want 204", current_pc); end
    checks++; if (trap_value !== 32'h0) begin errors++; $display("[TB] FAIL irq_tval got %h want 0", trap_value); end
    @(negedge clk);
    clear_inputs(); redirect_ready = 1;
    #1;
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("[TB] FAIL irq_redirect_pc got %h want 80", redirect_pc); end
    repeat (N + 1) @(negedge clk);
    #1;
    checks++; if (external_interrupt !== 1'b0) begin errors++; $display("[TB] FAIL irq_drain got %b want 0", external_interrupt); end
    @(negedge clk);
  endtask

  task automatic test_mret();
    clear_inputs();
    retire_valid = 1; retire_mret = 1; retire_exc = 1; retire_cause = 31'd5;
    retire_pc = 32'h280; ret_pc = 32'h300; trap_pc = 32'h80;
    #1;
    checks++; if (exit_trap !== 1'b0) begin errors++; $display("[TB] FAIL mret_exc_exit got %b want 0", exit_trap); end
    checks++; if (handle_trap !== 1'b1) begin errors++; $display("[TB] FAIL mret_exc_trap got %b want 1", handle_trap); end
    checks++; if (exception !== 1'b1) begin errors++; $display("[TB] FAIL mret_exc_exception got %b want 1", exception); end
    @(negedge clk);
    clear_inputs(); redirect_ready = 1;
    #1;
    checks++; if (redirect_pc !== 32'h80) begin errors++; $display("[TB] FAIL mret_exc_pc got %h want 80", redirect_pc); end
    @(negedge clk);
    retire_valid = 1; retire_mret = 1; ret_pc = 32'h300; redirect_ready = 0;
    #1;
    checks++; if (exit_trap !== 1'b1) begin errors++; $display("[TB] FAIL mret_exit got %b want 1", exit_trap); end
    checks++; if (handle_trap !== 1'b0) begin errors++; $display("[TB] FAIL mret_no_trap got %b want 0", handle_trap); end
    @(negedge clk); #1;
    checks++; if (exit_trap !== 1'b0) begin errors++; $display("[TB] FAIL mret_pulse got %b want 0", exit_trap); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL mret_valid got %b want 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h300) begin errors++; $display("[TB] FAIL mret_pc got %h want 300", redirect_pc); end
    clear_inputs(); redirect_ready = 1;
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL mret_run got %b want 0", stall); end
    @(negedge clk);
  endtask

  task automatic test_wfi();
    clear_inputs();
    retire_valid = 1; retire_wfi = 1; retire_pc = 32'h40; retire_next_pc = 32'h44;
    #1;
    checks++; if (handle_trap !== 1'b0 || exit_trap !== 1'b0) begin errors++; $display("[TB] FAIL wfi_pulses got %b%b want 00", handle_trap, exit_trap); end
    @(negedge clk);
    clear_inputs();
`ifdef TRAP_CTRL_WFI_EN
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL wfi_stall got %b want 1", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL wfi_valid got %b want 0", redirect_valid); end
    repeat (3) @(negedge clk);
    tmr_irq_raw = 1;
    repeat (N) @(negedge clk);
    #1;
    checks++; if (timer_interrupt !== 1'b1) begin errors++; $display("[TB] FAIL wfi_tmr got %b want 1", timer_interrupt); end
    checks++; if (stall !== 1'b1 || handle_trap !== 1'b0) begin errors++; $display("[TB] FAIL wfi_wake_cycle got stall=%b trap=%b want 1 0", stall, handle_trap); end
    @(negedge clk); #1;
    checks++; if (stall !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL wfi_wake_run got stall=%b valid=%b want 0 0", stall, redirect_valid); end
    tmr_irq_raw = 0;
    repeat (N + 1) @(negedge clk);
    retire_valid = 1; retire_wfi = 1; retire_pc = 32'h44; retire_next_pc = 32'h48;
    @(negedge clk);
    clear_inputs();
    sw_irq_raw = 1; interrupted = 1; trap_pc = 32'h80;
    repeat (N) @(negedge clk);
    #1;
    checks++; if (handle_trap !== 1'b1) begin errors++; $display("[TB] FAIL wfi_irq_trap got %b want 1", handle_trap); end
    checks++; if (current_pc !== 32'h48) begin errors++; $display("[TB] FAIL wfi_irq_pc got %h want 48", current_pc); end
    checks++; if (exception !== 1'b0) begin errors++; $display("[TB] FAIL wfi_irq_exc got %b want 0", exception); end
    @(negedge clk); #1;
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin errors++; $display("[TB] FAIL wfi_irq_redirect got %b %h want 1 80", redirect_valid, redirect_pc); end
    clear_inputs(); redirect_ready = 1;
    repeat (N + 1) @(negedge clk);
`else
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL wfi_off_stall got %b want 0", stall); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL wfi_off_valid got %b want 0", redirect_valid); end
    @(negedge clk);
`endif
  endtask

  task automatic test_reset_mid_trap();
    clear_inputs();
    retire_valid = 1; retire_exc = 1; trap_pc = 32'h80;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmt_pending got %b want 1", redirect_valid); end
    #2 reset = 1;
    #1;
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmt_valid got %b want 0", redirect_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL rmt_stall got %b want 0", stall); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL rmt_pc got %h want 0", redirect_pc); end
    @(negedge clk);
    reset = 0;
    retire_valid = 1; retire_exc = 1; trap_pc = 32'h90;
    #1;
    checks++; if (handle_trap !== 1'b1 || stall !== 1'b0) begin errors++; $display("[TB] FAIL rmt_run got trap=%b stall=%b want 1 0", handle_trap, stall); end
    @(negedge clk);
    clear_inputs(); redirect_ready = 1;
    #1;
    checks++; if (redirect_pc !== 32'h90) begin errors++; $display("[TB] FAIL rmt_new_pc got %h want 90", redirect_pc); end
    @(negedge clk);
  endtask

  // Reference model: mode 0=RUN 1=TRAP 2=RET 3=WAIT; irq lines are the raw
  // value seen N clock edges earlier.
  task automatic test_random();
    int mode;
    int act;
    logic [31:0] m_redir, m_wfi;
    bit ext_h[$], tmr_h[$], sw_h[$];
    logic e_ht, e_et, e_exc, e_rv, e_stall;
    logic [30:0] e_cause;
    logic [31:0] e_tval, e_cpc;
    clear_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;
    mode = 0; m_redir = '0; m_wfi = '0;
    for (int i = 0; i < N; i++) begin ext_h.push_back(0); tmr_h.push_back(0); sw_h.push_back(0); end
    for (int cyc = 0; cyc < 600; cyc++) begin
      retire_valid   = ($urandom_range(0, 3) != 0);
      retire_exc     = ($urandom_range(0, 7) == 0);
      retire_mret    = ($urandom_range(0, 5) == 0);
      retire_wfi     = ($urandom_range(0, 4) == 0);
      interrupted    = ($urandom_range(0, 6) == 0);
      retire_cause   = 31'($urandom);
      retire_pc      = $urandom; retire_next_pc = $urandom; retire_tval = $urandom;
      trap_pc        = $urandom; ret_pc = $urandom;
      redirect_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) ext_irq_raw = ~ext_irq_raw;
      if ($urandom_range(0, 9) == 0) tmr_irq_raw = ~tmr_irq_raw;
      if ($urandom_range(0, 9) == 0) sw_irq_raw  = ~sw_irq_raw;
      // act: 0 none, 1 exception, 2 interrupt, 3 mret, 4 wfi, 5 wake to trap, 6 wake to run
      act = 0;
      if (mode == 0 && retire_valid) begin
        if (retire_exc) act = 1;
        else if (interrupted) act = 2;
        else if (retire_mret) act = 3;
        else if (WFI_EN && retire_wfi) act = 4;
      end else if (mode == 3 && (ext_h[0] || tmr_h[0] || sw_h[0])) begin
        act = interrupted ? 5 : 6;
      end
      e_ht = (act == 1 || act == 2 || act == 5);
      e_et = (act == 3);
      e_exc = (act == 1);
      e_cause = (act == 1) ? retire_cause : '0;
      e_tval = (act == 1) ? retire_tval : '0;
      e_cpc = (act == 1) ? retire_pc : (act == 2) ? retire_next_pc : (act == 5) ? m_wfi : '0;
      e_rv = (mode == 1 || mode == 2);
      e_stall = (mode != 0);
      #1;
      checks++; if ({external_interrupt, timer_interrupt, software_interrupt} !== {ext_h[0], tmr_h[0], sw_h[0]}) begin errors++; $display("[TB] FAIL rnd_irq[%0d] got %b want %b", cyc, {external_interrupt, timer_interrupt, software_interrupt}, {ext_h[0], tmr_h[0], sw_h[0]}); end
      checks++; if (handle_trap !== e_ht) begin errors++; $display("[TB] FAIL rnd_handle_trap[%0d] got %b want %b", cyc, handle_trap, e_ht); end
      checks++; if (exit_trap !== e_et) begin errors++; $display("[TB] FAIL rnd_exit_trap[%0d] got %b want %b", cyc, exit_trap, e_et); end
      checks++; if (exception !== e_exc) begin errors++; $display("[TB] FAIL rnd_exception[%0d] got %b want %b", cyc, exception, e_exc); end
      checks++; if (exception_cause !== e_cause) begin errors++; $display("[TB] FAIL rnd_cause[%0d] got %h want %h", cyc, exception_cause, e_cause); end
      checks++; if (trap_value !== e_tval) begin errors++; $display("[TB] FAIL rnd_tval[%0d] got %h want %h", cyc, trap_value, e_tval); end
      checks++; if (current_pc !== e_cpc) begin errors++; $display("[TB] FAIL rnd_current_pc[%0d] got %h want %h", cyc, current_pc, e_cpc); end
      checks++; if (redirect_valid !== e_rv) begin errors++; $display("[TB] FAIL rnd_redirect_valid[%0d] got %b want %b", cyc, redirect_valid, e_rv); end
      checks++; if (stall !== e_stall) begin errors++; $display("[TB] FAIL rnd_stall[%0d] got %b want %b", cyc, stall, e_stall); end
      checks++; if (redirect_pc !== m_redir) begin errors++; $display("[TB] FAIL rnd_redirect_pc[%0d] got %h want %h", cyc, redirect_pc, m_redir); end
      @(negedge clk);
      ext_h.push_back(ext_irq_raw); void'(ext_h.pop_front());
      tmr_h.push_back(tmr_irq_raw); void'(tmr_h.pop_front());
      sw_h.push_back(sw_irq_raw);   void'(sw_h.pop_front());
      case (act)
        1, 2, 5: begin mode = 1; m_redir = trap_pc; end
        3:       begin mode = 2; m_redir = ret_pc; end
        4:       begin mode = 3; m_wfi = retire_next_pc; end
        6:       mode = 0;
        default: if ((mode == 1 || mode == 2) && redirect_ready) mode = 0;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_backpressure();
    test_interrupt();
    test_mret();
    test_wfi();
    test_reset_mid_trap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
